// File: rtl/pipe_ctrl_unit.sv
// Main control decode for the five-stage core: decodes the ID opcode, carries the
// control groups through ID/EX, EX/MEM and MEM/WB, and detects load-use hazards.
module pipe_ctrl_unit #(
  parameter int ALUOP_W   = 2,
  parameter int RF_ADDR_W = 5,
  parameter int EXT_OPS   = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold_i,
  input  logic                 flush_i,
  input  logic                 id_valid,
  input  logic [6:0]           id_opcode,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  output logic                 stall_req,
  output logic                 ex_alusrc,
  output logic [1:0]           ex_asel,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic                 ex_branch,
  output logic                 ex_jal,
  output logic                 ex_jalr,
  output logic                 ex_illegal,
  output logic [RF_ADDR_W-1:0] ex_rd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_regwrite,
  output logic [1:0]           wb_sel,
  output logic [RF_ADDR_W-1:0] wb_rd
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

  // Decoded control word for the ID instruction
  logic                 dec_alusrc;
  logic [1:0]           dec_asel;
  logic [ALUOP_W-1:0]   dec_aluop;
  logic                 dec_branch;
  logic                 dec_jal;
  logic                 dec_jalr;
  logic                 dec_illegal;
  logic                 dec_mem_read;
  logic                 dec_mem_write;
  logic                 dec_regwrite;
  logic [1:0]           dec_wb_sel;
  logic [RF_ADDR_W-1:0] dec_rd;

  // ID/EX fields that are not visible as ex_* outputs
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic                 ex_regwrite;
  logic [1:0]           ex_wb_sel;

  // EX/MEM fields that are not visible as mem_* outputs
  logic                 mem_regwrite;
  logic [1:0]           mem_wb_sel;
  logic [RF_ADDR_W-1:0] mem_rd;

  logic                 take_id;

  always_comb begin
    dec_alusrc    = 1'b0;
    dec_asel      = 2'b00;
    dec_aluop     = ALU_ADD;
    dec_branch    = 1'b0;
    dec_jal       = 1'b0;
    dec_jalr      = 1'b0;
    dec_illegal   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_regwrite  = 1'b0;
    dec_wb_sel    = 2'b00;
    if (id_valid) begin
      case (id_opcode)
        OP_R: begin
          dec_regwrite = 1'b1;
          dec_aluop    = ALU_R;
        end
        OP_I: begin
          dec_alusrc   = 1'b1;
          dec_regwrite = 1'b1;
          dec_aluop    = ALU_I;
        end
        OP_LOAD: begin
          dec_alusrc   = 1'b1;
          dec_mem_read = 1'b1;
          dec_regwrite = 1'b1;
          dec_wb_sel   = 2'b01;
        end
        OP_STORE: begin
          dec_alusrc    = 1'b1;
          dec_mem_write = 1'b1;
        end
        OP_BRANCH: begin
          dec_branch = 1'b1;
          dec_aluop  = ALU_BR;
        end
        OP_JAL: begin
          dec_jal      = 1'b1;
          dec_regwrite = 1'b1;
          dec_wb_sel   = 2'b10;
        end
        OP_JALR: begin
          dec_jalr     = 1'b1;
          dec_alusrc   = 1'b1;
          dec_regwrite = 1'b1;
          dec_wb_sel   = 2'b10;
        end
        OP_LUI: begin
          if (EXT_OPS != 0) begin
            dec_alusrc   = 1'b1;
            dec_asel     = 2'b10;
            dec_regwrite = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_AUIPC: begin
          if (EXT_OPS != 0) begin
            dec_alusrc   = 1'b1;
            dec_asel     = 2'b01;
            dec_regwrite = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    // Non-writing instructions carry rd=0 so they can never match a hazard compare
    dec_rd = dec_regwrite ? id_rd : '0;
  end

  assign stall_req = (HAZARD_EN != 0) && id_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Flush and stall both replace the ID instruction with an all-zero bubble
  assign take_id = !(flush_i || stall_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_alusrc    <= 1'b0;
      ex_asel      <= 2'b00;
      ex_aluop     <= '0;
      ex_branch    <= 1'b0;
      ex_jal       <= 1'b0;
      ex_jalr      <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_wb_sel    <= 2'b00;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_wb_sel   <= 2'b00;
      mem_rd       <= '0;
      wb_regwrite  <= 1'b0;
      wb_sel       <= 2'b00;
      wb_rd        <= '0;
    end else if (!hold_i) begin
      ex_alusrc    <= dec_alusrc & take_id;
      ex_asel      <= take_id ? dec_asel : 2'b00;
      ex_aluop     <= take_id ? dec_aluop : '0;
      ex_branch    <= dec_branch & take_id;
      ex_jal       <= dec_jal & take_id;
      ex_jalr      <= dec_jalr & take_id;
      ex_illegal   <= dec_illegal & take_id;
      ex_rd        <= take_id ? dec_rd : '0;
      ex_mem_read  <= dec_mem_read & take_id;
      ex_mem_write <= dec_mem_write & take_id;
      ex_regwrite  <= dec_regwrite & take_id;
      ex_wb_sel    <= take_id ? dec_wb_sel : 2'b00;
      mem_read     <= ex_mem_read;
      mem_write    <= ex_mem_write;
      mem_regwrite <= ex_regwrite;
      mem_wb_sel   <= ex_wb_sel;
      mem_rd       <= ex_rd;
      wb_regwrite  <= mem_regwrite;
      wb_sel       <= mem_wb_sel;
      wb_rd        <= mem_rd;
    end
  end

endmodule
